// File: rtl/sid_pot_pkg.sv
// rtl/sid_pot_pkg.sv - shared types and constants for the SID pot conditioner
// Contents: POT_W sample width, SID register addresses for POTX/POTY,
// the pot-sample struct and a median-of-3 helper.
package sid_pot_pkg;

  localparam int POT_W = 8;

  localparam logic [4:0] SID_REG_POTX = 5'h19;
  localparam logic [4:0] SID_REG_POTY = 5'h1A;

  typedef struct packed {
    logic             valid;
    logic [POT_W-1:0] x;
    logic [POT_W-1:0] y;
  } pot_sample_t;

  // Median of three: clamp c into the [min(a,b), max(a,b)] interval.
  function automatic logic [POT_W-1:0] med3(input logic [POT_W-1:0] a,
                                            input logic [POT_W-1:0] b,
                                            input logic [POT_W-1:0] c);
    logic [POT_W-1:0] lo;
    logic [POT_W-1:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c <= lo) return lo;
    else if (c >= hi) return hi;
    else return c;
  endfunction

endpackage

// File: rtl/sid_pot_chan.sv
// rtl/sid_pot_chan.sv - one pot channel: median, IIR smoothing, hysteresis
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   stb_i, prime_i         new raw sample at S1; prime_i marks the priming sample
//   s1_v_i, s1_prime_i     S1 holds a valid (priming) sample, consumed by S2
//   s2_v_i, s2_prime_i     S2 holds a valid (priming) sample, consumed by S3
//   val_i                  raw conversion
//   out_o                  conditioned output
// Build option: SID_POT_MEDIAN_EN enables the median-of-3 history in S1;
// without it S1 is a plain register stage with the same latency.
module sid_pot_chan
  import sid_pot_pkg::*;
#(
  parameter int AVG_SHIFT = 2,
  parameter int HYST      = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stb_i,
  input  logic             prime_i,
  input  logic             s1_v_i,
  input  logic             s1_prime_i,
  input  logic             s2_v_i,
  input  logic             s2_prime_i,
  input  logic [POT_W-1:0] val_i,
  output logic [POT_W-1:0] out_o
);

  localparam int ACC_W = POT_W + AVG_SHIFT;
  localparam logic [POT_W:0] HYST_W = (POT_W+1)'(HYST);

  logic [POT_W-1:0] med_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [POT_W-1:0] filt;
  logic [POT_W-1:0] out_q;
  logic [POT_W:0]   diff;
  logic [POT_W:0]   mag;
  logic             take;

  // S1
`ifdef SID_POT_MEDIAN_EN
  logic [POT_W-1:0] h0_q;
  logic [POT_W-1:0] h1_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h0_q  <= '0;
      h1_q  <= '0;
      med_q <= '0;
    end else if (stb_i) begin
      if (prime_i) begin
        // Fill the history so the first medians are not dragged toward zero.
        h0_q  <= val_i;
        h1_q  <= val_i;
        med_q <= val_i;
      end else begin
        med_q <= med3(val_i, h0_q, h1_q);
        h1_q  <= h0_q;
        h0_q  <= val_i;
      end
    end
  end
`else
  logic unused_prime;
  assign unused_prime = prime_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      med_q <= '0;
    end else if (stb_i) begin
      med_q <= val_i;
    end
  end
`endif

  // S2: acc tracks filt scaled by 2^AVG_SHIFT; bounded by 255*2^AVG_SHIFT.
  always_comb begin
    acc_d = acc_q - (acc_q >> AVG_SHIFT) + ACC_W'(med_q);
    if (s1_prime_i) begin
      acc_d = ACC_W'(med_q) << AVG_SHIFT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (s1_v_i) begin
      acc_q <= acc_d;
    end
  end

  assign filt = acc_q[AVG_SHIFT +: POT_W];

  // S3: endpoints always pass so 0 and 255 stay reachable despite hysteresis.
  always_comb begin
    diff = {1'b0, filt} - {1'b0, out_q};
    mag  = diff[POT_W] ? -diff : diff;
    take = s2_prime_i || (mag >= HYST_W) || (filt == '0) || (filt == '1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else if (s2_v_i && take) begin
      out_q <= filt;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/sid_pot_cond.sv
// rtl/sid_pot_cond.sv - SID POTX/POTY conditioner with register read port
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   pot_stb                one-clk strobe, potx_val/poty_val carry a conversion
//   potx_val, poty_val     raw conversions
//   rd_en, rd_addr         register read request ($19 POTX, $1A POTY)
//   rd_data, rd_valid      read response, one clk after rd_en
//   potx_out, poty_out     conditioned values
// Build option: SID_POT_MEDIAN_EN enables median-of-3 spike rejection.
module sid_pot_cond
  import sid_pot_pkg::*;
#(
  parameter int AVG_SHIFT = 2,
  parameter int HYST      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pot_stb,
  input  logic [POT_W-1:0] potx_val,
  input  logic [POT_W-1:0] poty_val,
  input  logic             rd_en,
  input  logic [4:0]       rd_addr,
  output logic [POT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [POT_W-1:0] potx_out,
  output logic [POT_W-1:0] poty_out
);

  pot_sample_t smp;
  logic        prime;
  logic        primed_q;
  logic        s1_v_q;
  logic        s1_p_q;
  logic        s2_v_q;
  logic        s2_p_q;
  logic [POT_W-1:0] rd_data_q;
  logic             rd_valid_q;

  assign smp   = '{valid: pot_stb, x: potx_val, y: poty_val};
  assign prime = smp.valid && !primed_q;

  // Valid/prime bits ride alongside the samples; no stall, every strobe is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      primed_q <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_p_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s2_p_q   <= 1'b0;
    end else begin
      if (smp.valid) primed_q <= 1'b1;
      s1_v_q <= smp.valid;
      s1_p_q <= prime;
      s2_v_q <= s1_v_q;
      s2_p_q <= s1_p_q;
    end
  end

  sid_pot_chan #(.AVG_SHIFT(AVG_SHIFT), .HYST(HYST)) u_chan_x (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .stb_i      (smp.valid),
    .prime_i    (prime),
    .s1_v_i     (s1_v_q),
    .s1_prime_i (s1_p_q),
    .s2_v_i     (s2_v_q),
    .s2_prime_i (s2_p_q),
    .val_i      (smp.x),
    .out_o      (potx_out)
  );

  sid_pot_chan #(.AVG_SHIFT(AVG_SHIFT), .HYST(HYST)) u_chan_y (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .stb_i      (smp.valid),
    .prime_i    (prime),
    .s1_v_i     (s1_v_q),
    .s1_prime_i (s1_p_q),
    .s2_v_i     (s2_v_q),
    .s2_prime_i (s2_p_q),
    .val_i      (smp.y),
    .out_o      (poty_out)
  );

  // Read samples the outputs before any same-edge S3 update lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (rd_en) begin
        case (rd_addr)
          SID_REG_POTX: begin
            rd_data_q  <= potx_out;
            rd_valid_q <= 1'b1;
          end
          SID_REG_POTY: begin
            rd_data_q  <= poty_out;
            rd_valid_q <= 1'b1;
          end
          default: rd_data_q <= '0;
        endcase
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sid_pot_cond.sv
// tb/tb_sid_pot_cond.sv - self-checking bench for sid_pot_cond
module tb_sid_pot_cond;

  localparam int AVG_SHIFT = 2;
  localparam int HYST      = 2;
`ifdef SID_POT_MEDIAN_EN
  localparam bit MED_EN = 1'b1;
`else
  localparam bit MED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pot_stb;
  logic [7:0] potx_val;
  logic [7:0] poty_val;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] potx_out;
  logic [7:0] poty_out;

  always #5 clk = ~clk;

  sid_pot_cond #(.AVG_SHIFT(AVG_SHIFT), .HYST(HYST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pot_stb  (pot_stb),
    .potx_val (potx_val),
    .poty_val (poty_val),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .potx_out (potx_out),
    .poty_out (poty_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: each sample's final output is computed the moment it is
  // strobed, then scheduled to become visible two edges later.
  typedef struct {
    int due;
    int x;
    int y;
  } pend_t;

  pend_t pend[$];
  int cyc = 0;
  int primed = 0;
  int h0[2], h1[2], acc[2], mout[2], vis[2];
  int exp_rd_data = 0;
  int exp_rd_valid = 0;
  int last_val = 128;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_sample(input int ch, input int v);
    int m;
    int f;
    int d;
    int t[$];
    if (primed == 0) begin
      h0[ch] = v;
      h1[ch] = v;
      acc[ch] = v << AVG_SHIFT;
      mout[ch] = v;
      return;
    end
    m = v;
    if (MED_EN) begin
      t = '{v, h0[ch], h1[ch]};
      t.sort();
      m = t[1];
    end
    h1[ch] = h0[ch];
    h0[ch] = v;
    acc[ch] = acc[ch] - (acc[ch] >> AVG_SHIFT) + m;
    f = (acc[ch] >> AVG_SHIFT) & 255;
    d = f - mout[ch];
    if (d < 0) d = -d;
    if (d >= HYST || f == 0 || f == 255) mout[ch] = f;
  endfunction

  task automatic model_edge();
    cyc++;
    if (!rst_n) begin
      pend.delete();
      primed = 0;
      for (int c = 0; c < 2; c++) begin
        h0[c] = 0; h1[c] = 0; acc[c] = 0; mout[c] = 0; vis[c] = 0;
      end
      exp_rd_data = 0;
      exp_rd_valid = 0;
      return;
    end
    if (rd_en) begin
      if (rd_addr == 5'h19) begin
        exp_rd_data = vis[0]; exp_rd_valid = 1;
      end else if (rd_addr == 5'h1A) begin
        exp_rd_data = vis[1]; exp_rd_valid = 1;
      end else begin
        exp_rd_data = 0; exp_rd_valid = 0;
      end
    end else begin
      exp_rd_valid = 0;
    end
    while (pend.size() > 0 && pend[0].due <= cyc) begin
      vis[0] = pend[0].x;
      vis[1] = pend[0].y;
      void'(pend.pop_front());
    end
    if (pot_stb) begin
      model_sample(0, int'(potx_val));
      model_sample(1, int'(poty_val));
      primed = 1;
      pend.push_back('{cyc + 2, mout[0], mout[1]});
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("potx_out", int'(potx_out), vis[0]);
      check("poty_out", int'(poty_out), vis[1]);
      check("rd_valid", int'(rd_valid), exp_rd_valid);
      check("rd_data",  int'(rd_data),  exp_rd_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [7:0] x, input logic [7:0] y);
    pot_stb = 1'b1;
    potx_val = x;
    poty_val = y;
    tick();
    pot_stb = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    rd_en = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pick();
    int v;
    case ($urandom_range(0, 3))
      0: v = int'($urandom_range(0, 255));
      1: v = int'($urandom_range(0, 3));
      2: v = int'($urandom_range(252, 255));
      default: begin
        v = last_val + int'($urandom_range(0, 8)) - 4;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end
    endcase
    last_val = v;
    return 8'(v);
  endfunction

  initial begin
    rst_n = 1'b0;
    pot_stb = 1'b0;
    potx_val = '0;
    poty_val = '0;
    rd_en = 1'b0;
    rd_addr = '0;
    idle(2);
    chk_en = 1'b1;
    check("reset_potx", int'(potx_out), 0);
    check("reset_poty", int'(poty_out), 0);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    tick();

    // Priming and latency
    strobe(8'd100, 8'd200);
    idle(1);
    check("latency_early", int'(potx_out), 0);
    idle(1);
    check("prime_x", int'(potx_out), 100);
    check("prime_y", int'(poty_out), 200);
    rd(5'h19);
    check("read_x_data", int'(rd_data), 100);
    check("read_x_valid", int'(rd_valid), 1);
    rd(5'h1A);
    check("read_y_data", int'(rd_data), 200);

    // Spike rejection
    strobe(8'd100, 8'd200);
    idle(3);
    strobe(8'd250, 8'd200);
    idle(3);
    check("spike_250", int'(potx_out), MED_EN ? 100 : 137);
    strobe(8'd100, 8'd200);
    idle(3);
    check("spike_after", int'(potx_out), MED_EN ? 100 : 128);

    // Hysteresis holds a 1-LSB change
    do_reset();
    strobe(8'd100, 8'd50);
    repeat (8) strobe(8'd101, 8'd50);
    idle(3);
    check("hyst_hold", int'(potx_out), 100);

    // Endpoints reachable
    do_reset();
    strobe(8'd10, 8'd245);
    repeat (40) strobe(8'd0, 8'd255);
    idle(3);
    check("end_zero", int'(potx_out), 0);
    check("end_full", int'(poty_out), 255);

    // Read coincident with an S3 update
    do_reset();
    strobe(8'd100, 8'd50);
    idle(3);
    strobe(8'd120, 8'd50);
    idle(1);
    rd(5'h19);
    check("coincident_read", int'(rd_data), 100);
    rd(5'h19);
    check("following_read", int'(rd_data), MED_EN ? 100 : 105);
    rd(5'h1B);
    check("bad_addr_valid", int'(rd_valid), 0);
    check("bad_addr_data", int'(rd_data), 0);
    idle(2);

    // Reset mid-pipeline
    strobe(8'd200, 8'd200);
    strobe(8'd210, 8'd10);
    do_reset();
    check("midrst_x", int'(potx_out), 0);
    check("midrst_y", int'(poty_out), 0);
    idle(3);
    check("midrst_flushed", int'(potx_out), 0);
    strobe(8'd50, 8'd60);
    idle(2);
    check("reprime_x", int'(potx_out), 50);
    check("reprime_y", int'(poty_out), 60);
    idle(5);
    check("reprime_no_tail", int'(potx_out), 50);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      pot_stb = ($urandom_range(0, 1) == 1);
      potx_val = pick();
      poty_val = pick();
      rd_en = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: rd_addr = 5'h19;
        1: rd_addr = 5'h1A;
        2: rd_addr = 5'($urandom_range(0, 31));
        default: rd_addr = 5'h19;
      endcase
      tick();
    end
    rst_n = 1'b1;
    pot_stb = 1'b0;
    rd_en = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
